multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 69 ++++++
 rtl/multicycle_controller_timer.sv | 30 +++
 rtl/multicycle_controller.sv | 169 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller:
// FSM states, opcode/funct values, ALU codes and datapath mux selects.
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_XOR = 4'd2;
    localparam logic [3:0] ALU_SLT = 4'd3;

    localparam logic [1:0] DEST_RD  = 2'd0;
    localparam logic [1:0] DEST_RT  = 2'd1;
    localparam logic [1:0] DEST_R31 = 2'd2;

    localparam logic [1:0] REGIN_ALU = 2'd0;
    localparam logic [1:0] REGIN_DM  = 2'd1;
    localparam logic [1:0] REGIN_PC4 = 2'd2;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) ||
                           (fn == FN_SLT) || (fn == FN_JR);
            OP_LW, OP_SW, OP_J, OP_JAL,
            OP_BNE, OP_ADDI, OP_XORI: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
        logic [3:0] a;
        a = ALU_ADD;
        case (fn)
            FN_SUB:  a = ALU_SUB;
            FN_SLT:  a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/multicycle_controller_timer.sv
// MEM-state wait counter: counts stalled cycles and flags the cycle
// in which one more stall would reach the configured limit.
module mem_wait_timer
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_q;

    // Count stalled MEM cycles; held at zero whenever not waiting in MEM.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= 8'd0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_controller.sv
// Five-state multicycle controller with decoded datapath controls,
// memory wait timeout and sticky illegal/timeout fault flags.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_WE,
    output logic       DM_WE,
    output logic       op_imm,
    output logic       mem_req,
    output logic [3:0] ALU_op,
    output logic [1:0] dest_add,
    output logic [1:0] reg_in,
    output logic [1:0] pc_src,
    output logic [2:0] state,
    output logic       illegal,
    output logic       timeout
);

    state_e     state_q;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic       illegal_q;
    logic       timeout_q;
    logic       expired;
    logic       dec_legal;
    logic       dec_jr;

    assign dec_legal = is_legal(opcode, funct);
    assign dec_jr    = (opcode == OP_RTYPE) && (funct == FN_JR);

    mem_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q != S_MEM),
        .inc_i    ((state_q == S_MEM) && !mem_ready),
        .expired_o(expired)
    );

    // State sequencing, opcode/funct capture and sticky fault flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            fn_q      <= 6'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    fn_q <= funct;
                    if (!dec_legal) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end else if (opcode == OP_J || opcode == OP_JAL || dec_jr) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (op_q == OP_LW || op_q == OP_SW) begin
                        state_q <= S_MEM;
                    end else if (op_q == OP_BNE) begin
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state_q <= (op_q == OP_LW) ? S_WRITEBACK : S_FETCH;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                S_WRITEBACK: state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Control decode from the registered state; DECODE looks at the live IR.
    always_comb begin
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        reg_WE   = 1'b0;
        DM_WE    = 1'b0;
        op_imm   = 1'b0;
        mem_req  = 1'b0;
        ALU_op   = ALU_ADD;
        dest_add = DEST_RD;
        reg_in   = REGIN_ALU;
        pc_src   = PC_PLUS4;
        case (state_q)
            S_FETCH: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
            end
            S_DECODE: begin
                if (dec_legal) begin
                    if (opcode == OP_J || opcode == OP_JAL) begin
                        pc_we  = 1'b1;
                        pc_src = PC_JUMP;
                    end
                    if (opcode == OP_JAL) begin
                        reg_WE   = 1'b1;
                        dest_add = DEST_R31;
                        reg_in   = REGIN_PC4;
                    end
                    if (dec_jr) begin
                        pc_we  = 1'b1;
                        pc_src = PC_RS;
                    end
                end
            end
            S_EXECUTE: begin
                case (op_q)
                    OP_RTYPE: ALU_op = rtype_alu(fn_q);
                    OP_ADDI, OP_LW, OP_SW: op_imm = 1'b1;
                    OP_XORI: begin
                        ALU_op = ALU_XOR;
                        op_imm = 1'b1;
                    end
                    OP_BNE: begin
                        ALU_op = ALU_SUB;
                        pc_src = PC_BRANCH;
                        pc_we  = !zero;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                op_imm  = 1'b1;
                DM_WE   = (op_q == OP_SW) && mem_ready;
            end
            S_WRITEBACK: begin
                reg_WE = 1'b1;
                if (op_q != OP_RTYPE) begin
                    dest_add = DEST_RT;
                end
                if (op_q == OP_LW) begin
                    reg_in = REGIN_DM;
                end
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller (MEM_TIMEOUT = 4);
// compares the full control bundle every cycle against hand-written values.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, ir_we, reg_WE, DM_WE, op_imm, mem_req;
    logic [3:0] ALU_op;
    logic [1:0] dest_add, reg_in, pc_src;
    logic [2:0] state;
    logic       illegal, timeout;

    int n_pass = 0;
    int n_tot  = 0;
    logic e_ill = 1'b0;
    logic e_to  = 1'b0;
    logic [20:0] obs;
    logic [20:0] e;

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .reg_WE(reg_WE), .DM_WE(DM_WE),
        .op_imm(op_imm), .mem_req(mem_req), .ALU_op(ALU_op),
        .dest_add(dest_add), .reg_in(reg_in), .pc_src(pc_src),
        .state(state), .illegal(illegal), .timeout(timeout)
    );

    assign obs = {state, pc_we, ir_we, reg_WE, DM_WE, op_imm, mem_req,
                  ALU_op, dest_add, reg_in, pc_src, illegal, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fl = {pc_we, ir_we, reg_WE, DM_WE, op_imm, mem_req}
    function automatic logic [20:0] ev(input logic [2:0] st, input logic [5:0] fl,
                                       input logic [3:0] alu, input logic [1:0] da,
                                       input logic [1:0] ri, input logic [1:0] ps);
        return {st, fl, alu, da, ri, ps, e_ill, e_to};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        #1;
        e = ev(3'd0, 6'b110000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL reset_fetch got=%h exp=%h", obs, e); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_add();
        opcode = 6'b000000; funct = 6'b100000; #1;
        e = ev(3'd0, 6'b110000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL add_fetch got=%h exp=%h", obs, e); else n_pass++;
        tick(); #1;
        e = ev(3'd1, 6'b000000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL add_decode got=%h exp=%h", obs, e); else n_pass++;
        tick();
        opcode = 6'b101011; funct = 6'b101010; #1;
        e = ev(3'd2, 6'b000000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL add_exec got=%h exp=%h", obs, e); else n_pass++;
        tick(); #1;
        e = ev(3'd4, 6'b001000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL add_wb got=%h exp=%h", obs, e); else n_pass++;
        tick(); #1;
        e = ev(3'd0, 6'b110000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL add_cycle5 got=%h exp=%h", obs, e); else n_pass++;
    endtask

    task automatic test_alu_ops();
        logic [5:0] t_op  [4] = '{6'b000000, 6'b000000, 6'b001000, 6'b001110};
        logic [5:0] t_fn  [4] = '{6'b100010, 6'b101010, 6'b000000, 6'b000000};
        logic [3:0] t_alu [4] = '{4'd1, 4'd3, 4'd0, 4'd2};
        logic [5:0] t_fl  [4] = '{6'b000000, 6'b000000, 6'b000010, 6'b000010};
        logic [1:0] t_da  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        for (int i = 0; i < 4; i++) begin
            opcode = t_op[i]; funct = t_fn[i];
            tick();
            tick(); #1;
            e = ev(3'd2, t_fl[i], t_alu[i], 2'd0, 2'd0, 2'd0);
            n_tot++;
            if (obs !== e) $display("FAIL alu%0d_exec got=%h exp=%h", i, obs, e); else n_pass++;
            tick(); #1;
            e = ev(3'd4, 6'b001000, 4'd0, t_da[i], 2'd0, 2'd0);
            n_tot++;
            if (obs !== e) $display("FAIL alu%0d_wb got=%h exp=%h", i, obs, e); else n_pass++;
            tick();
        end
    endtask

    task automatic test_lw();
        opcode = 6'b100011; funct = 6'b000000; mem_ready = 1'b0;
        tick(); #1;
        e = ev(3'd1, 6'b000000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL lw_decode got=%h exp=%h", obs, e); else n_pass++;
        tick(); #1;
        e = ev(3'd2, 6'b000010, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL lw_exec got=%h exp=%h", obs, e); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ready = (i == 3); #1;
            e = ev(3'd3, 6'b000011, 4'd0, 2'd0, 2'd0, 2'd0);
            n_tot++;
            if (obs !== e) $display("FAIL lw_mem%0d got=%h exp=%h", i, obs, e); else n_pass++;
        end
        tick();
        mem_ready = 1'b1; #1;
        e = ev(3'd4, 6'b001000, 4'd0, 2'd1, 2'd1, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL lw_wb got=%h exp=%h", obs, e); else n_pass++;
        tick(); #1;
        e = ev(3'd0, 6'b110000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL lw_fetch got=%h exp=%h", obs, e); else n_pass++;
        mem_ready = 1'b0;
    endtask

    task automatic test_sw(input int ready_at, input string nm);
        int dm_n;
        dm_n = 0;
        opcode = 6'b101011; funct = 6'b000000; mem_ready = 1'b0;
        tick();
        tick(); #1;
        e = ev(3'd2, 6'b000010, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL %s_exec got=%h exp=%h", nm, obs, e); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ready = (i == ready_at); #1;
            if (DM_WE) dm_n++;
            e = ev(3'd3, (i == ready_at) ? 6'b000111 : 6'b000011,
                   4'd0, 2'd0, 2'd0, 2'd0);
            n_tot++;
            if (obs !== e) $display("FAIL %s_mem%0d got=%h exp=%h", nm, i, obs, e); else n_pass++;
        end
        n_tot++;
        if (dm_n !== ((ready_at < 4) ? 1 : 0))
            $display("FAIL %s_dm_count got=%0d exp=%0d", nm, dm_n, (ready_at < 4) ? 1 : 0);
        else n_pass++;
        tick();
        mem_ready = 1'b0;
        if (ready_at >= 4) e_to = 1'b1;
        #1;
        e = ev(3'd0, 6'b110000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL %s_fetch got=%h exp=%h", nm, obs, e); else n_pass++;
    endtask

    task automatic test_bne();
        for (int z = 0; z < 2; z++) begin
            opcode = 6'b000101; funct = 6'b000000; zero = 1'b0;
            tick();
            tick();
            zero = z[0]; #1;
            e = ev(3'd2, z[0] ? 6'b000000 : 6'b100000, 4'd1, 2'd0, 2'd0, 2'd1);
            n_tot++;
            if (obs !== e) $display("FAIL bne_z%0d_exec got=%h exp=%h", z, obs, e); else n_pass++;
            tick(); #1;
            e = ev(3'd0, 6'b110000, 4'd0, 2'd0, 2'd0, 2'd0);
            n_tot++;
            if (obs !== e) $display("FAIL bne_z%0d_fetch got=%h exp=%h", z, obs, e); else n_pass++;
        end
        zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [5:0]  t_op [3] = '{6'b000010, 6'b000011, 6'b000000};
        logic [5:0]  t_fn [3] = '{6'b000000, 6'b000000, 6'b001000};
        logic [20:0] t_e  [3];
        t_e[0] = ev(3'd1, 6'b100000, 4'd0, 2'd0, 2'd0, 2'd2);
        t_e[1] = ev(3'd1, 6'b101000, 4'd0, 2'd2, 2'd2, 2'd2);
        t_e[2] = ev(3'd1, 6'b100000, 4'd0, 2'd0, 2'd0, 2'd3);
        for (int i = 0; i < 3; i++) begin
            opcode = t_op[i]; funct = t_fn[i];
            tick(); #1;
            n_tot++;
            if (obs !== t_e[i]) $display("FAIL jmp%0d_decode got=%h exp=%h", i, obs, t_e[i]);
            else n_pass++;
            tick(); #1;
            e = ev(3'd0, 6'b110000, 4'd0, 2'd0, 2'd0, 2'd0);
            n_tot++;
            if (obs !== e) $display("FAIL jmp%0d_fetch got=%h exp=%h", i, obs, e); else n_pass++;
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; funct = 6'b000000;
        tick(); #1;
        e = ev(3'd1, 6'b000000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL ill_decode got=%h exp=%h", obs, e); else n_pass++;
        tick();
        e_ill = 1'b1; #1;
        e = ev(3'd0, 6'b110000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL ill_fetch got=%h exp=%h", obs, e); else n_pass++;
        opcode = 6'b000010;
        tick();
        tick(); #1;
        e = ev(3'd0, 6'b110000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL ill_sticky got=%h exp=%h", obs, e); else n_pass++;
    endtask

    task automatic test_reset_mid_mem();
        opcode = 6'b100011; funct = 6'b000000; mem_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1; #1;
        e = ev(3'd3, 6'b000011, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL rst_in_mem got=%h exp=%h", obs, e); else n_pass++;
        tick();
        reset = 1'b0;
        e_ill = 1'b0;
        e_to = 1'b0; #1;
        e = ev(3'd0, 6'b110000, 4'd0, 2'd0, 2'd0, 2'd0);
        n_tot++;
        if (obs !== e) $display("FAIL rst_mem_fetch got=%h exp=%h", obs, e); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        opcode = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_add();
        test_alu_ops();
        test_lw();
        test_sw(3, "sw");
        test_bne();
        test_jumps();
        test_sw(4, "sw_to");
        test_illegal();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
